ahb_sram_responder: RTL



---
 rtl/ahb_sram_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder
//   AHB-Lite slave backed by a synchronous SRAM array, sitting on the protected
//   bus. It checks address/control parity and write-data checksums, produces a
//   read-data checksum, inserts WAIT_STATES extra data-phase cycles and answers
//   illegal transfers with the two-cycle AHB ERROR response.
//
//   Ports
//     s_clk_i, s_reset_i      clock, synchronous active-high reset
//     s_hsel_i .. s_hready_i  AHB-Lite address/control inputs
//     s_hwdata_i              write data, s_hwchecksum_i its (39,32) SECDED checksum
//     s_hparity_i             even parity over address bytes / control groups
//     s_hrdata_o              read data (holds between reads), s_hrchecksum_o its checksum
//     s_hreadyout_o, s_hresp_o  transfer done / OKAY(0) or ERROR(1)
//     s_fault_o               one-cycle pulse on a parity or checksum error
module ahb_sram_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [2:0]  s_hburst_i,
    input  logic [3:0]  s_hprot_i,
    input  logic        s_hmastlock_i,
    input  logic        s_hready_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [6:0]  s_hwchecksum_i,
    input  logic [5:0]  s_hparity_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_hreadyout_o,
    output logic        s_hresp_o,
    output logic        s_fault_o
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    // (39,32) SECDED: data bits occupy the non-power-of-two Hamming positions
    // 3..38; check bits [5:0] are the XOR of the positions of all set data
    // bits, bit 6 is the overall parity of data and check bits.
    function automatic logic [6:0] ecc_enc(input logic [31:0] d);
        logic [5:0] syn;
        int unsigned k;
        syn = '0;
        k   = 0;
        for (int unsigned pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[k[4:0]]) syn ^= pos[5:0];
                k++;
            end
        end
        return {^{d, syn}, syn};
    endfunction

    logic [31:0]   mem [MEM_WORDS];

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] widx_q;
    logic [1:0]    off_q, size_q;
    logic          write_q;
    logic          fault_d;
    logic          accept, par_err, addr_err;
    logic          mem_we, rd_en;
    logic [AW-1:0] rd_idx;
    logic [3:0]    be;
    logic [5:0]    par_calc;

    assign par_calc = {^{s_hburst_i, s_hprot_i, s_hmastlock_i},
                       ^{s_htrans_i, s_hwrite_i, s_hsize_i},
                       ^s_haddr_i[31:24], ^s_haddr_i[23:16],
                       ^s_haddr_i[15:8],  ^s_haddr_i[7:0]};
    assign par_err  = (par_calc != s_hparity_i);

    assign addr_err = par_err
                    || (s_hsize_i > 3'd2)
                    || ((s_hsize_i == 3'd1) && s_haddr_i[0])
                    || ((s_hsize_i == 3'd2) && (s_haddr_i[1:0] != 2'b00))
                    || ({2'b00, s_haddr_i[31:2]} >= 32'(MEM_WORDS));

    assign s_hreadyout_o = (state_q == IDLE) || (state_q == ERR2);
    assign s_hresp_o     = (state_q == ERR1) || (state_q == ERR2);
    assign accept        = s_hsel_i && s_htrans_i[1] && s_hready_i && s_hreadyout_o;

    always_comb begin
        be = '0;
        case (size_q)
            2'd0:    be[off_q] = 1'b1;
            2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
            default: be = '1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = 1'b0;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = widx_q;
        case (state_q)
            IDLE, ERR2: begin
                state_d = IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ERR1;
                        fault_d = par_err;
                    end else if (s_hwrite_i) begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_STATES) + 3'd1;
                    end else if (WAIT_STATES == 0) begin
                        rd_en  = 1'b1;
                        rd_idx = s_haddr_i[AW+1:2];
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 3'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    if (!write_q) begin
                        rd_en = 1'b1;
                    end else if (ecc_enc(s_hwdata_i) == s_hwchecksum_i) begin
                        mem_we = 1'b1;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ERR1;
                    end
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            widx_q         <= '0;
            off_q          <= '0;
            size_q         <= '0;
            write_q        <= 1'b0;
            s_fault_o      <= 1'b0;
            s_hrdata_o     <= '0;
            s_hrchecksum_o <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_fault_o <= fault_d;
            if (accept) begin
                widx_q  <= s_haddr_i[AW+1:2];
                off_q   <= s_haddr_i[1:0];
                size_q  <= s_hsize_i[1:0];
                write_q <= s_hwrite_i;
            end
            if (rd_en) begin
                s_hrdata_o     <= mem[rd_idx];
                s_hrchecksum_o <= ecc_enc(mem[rd_idx]);
            end
        end
    end

    // Array is not reset; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge s_clk_i) begin
        if (mem_we && !s_reset_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[widx_q][8*b +: 8] <= s_hwdata_i[8*b +: 8];
            end
        end
    end

endmodule
